em_video_timing_gen: RTL

Raster timing generator for the 720p60 output path. Runs in the 74.25 MHz pixel clock domain produced by the pixel PLL and waits for that PLL to report lock. Produces registered hsync, vsync, data-enable, pixel coordinates and a frame-start strobe for the pixel fetch and video output stages. Default parameters give CEA-861 1280x720 timing, 1650x750 total.

---
 rtl/em_video_timing_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/em_video_timing_gen.sv
// em_video_timing_gen: raster timing generator (hsync/vsync/de/x/y/frame_start)
//   for the pixel clock domain. Gated by a synchronized PLL lock plus a
//   settle delay. Latency: outputs are registered one cycle behind the
//   h/v counters. Backpressure: none; the raster free-runs while locked.
// Ports:
//   clk, rst (async active-high), locked (async PLL lock)
//   hsync, vsync (polarity SYNC_POL), de, x[11:0], y[11:0], frame_start, running
module em_video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int SYNC_POL  = 1,
  parameter int LOCK_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("em_video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end
    if (LOCK_WAIT < 1 || LOCK_WAIT > 65535) begin : g_bad_lock_wait
      $error("em_video_timing_gen: LOCK_WAIT out of range 1..65535");
    end
  endgenerate

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] LW_LAST  = 16'(LOCK_WAIT - 1);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] settle_cnt, settle_cnt_nxt;
  logic        lk_meta, lk_s;
  logic [11:0] h, v;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= 16'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        settle_cnt_nxt = 16'd0;
        if (lk_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        // Any lock drop here restarts the full settle wait from WAIT_LOCK.
        if (!lk_s)                      state_nxt = WAIT_LOCK;
        else if (settle_cnt == LW_LAST) state_nxt = RUN;
        else                            settle_cnt_nxt = settle_cnt + 16'd1;
      end
      RUN: begin
        if (!lk_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Raster counters advance only while staying in RUN; on entry to or exit
  // from RUN they sit at 0, so a restart always begins at the frame origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= 12'd0;
      v <= 12'd0;
    end else if (state == RUN && lk_s) begin
      if (h == H_LAST) begin
        h <= 12'd0;
        v <= (v == V_LAST) ? 12'd0 : v + 12'd1;
      end else begin
        h <= h + 12'd1;
      end
    end else begin
      h <= 12'd0;
      v <= 12'd0;
    end
  end

  // All outputs decoded from the same (h,v,state) and registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      x           <= 12'd0;
      y           <= 12'd0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else if (state == RUN) begin
      hsync       <= (h >= HS_START && h < HS_END) ? SYNC_ON : ~SYNC_ON;
      vsync       <= (v >= VS_START && v < VS_END) ? SYNC_ON : ~SYNC_ON;
      de          <= (h < H_ACT) && (v < V_ACT);
      x           <= h;
      y           <= v;
      frame_start <= (h == 12'd0) && (v == 12'd0);
      running     <= 1'b1;
    end else begin
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      x           <= 12'd0;
      y           <= 12'd0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end
  end

endmodule
